dm_bus_arbiter: RTL
===================

DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of bus requesters (harts or debug agents) sharing the DM bus port; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 255, maximum BUSY cycles without bus_ready before the transfer is aborted; legal range 4..1023.
REQ-003 Parameter ID_W, default 3, width of grant_id; SHALL satisfy 2**ID_W >= NUM_REQ.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester transfer request; held until matching req_ready.
REQ-007 req_write  input  NUM_REQ  per-requester write (1) / read (0).
REQ-008 req_addr  input  NUM_REQ*20  per-requester bus address; requester i in bits [20*i+19:20*i].
REQ-009 req_wdata  input  NUM_REQ*32  per-requester write data; requester i in bits [32*i+31:32*i].
REQ-010 req_ready  output  NUM_REQ  one-hot completion pulse to the granted requester.
REQ-011 req_rdata  output  32  read data, valid while any req_ready bit is 1.
REQ-012 req_err  output  1  timeout flag, valid while any req_ready bit is 1.
REQ-013 grant_id  output  ID_W  index of the current or last granted requester.
REQ-014 bus_valid  output  1  registered request to the DM bus slave.
REQ-015 bus_ready  input  1  DM bus slave completion.
REQ-016 bus_write  output  1  registered write flag.
REQ-017 bus_addr  output  20  registered address.
REQ-018 bus_wdata  output  32  registered write data.
REQ-019 bus_rdata  input  32  slave read data, valid with bus_ready.

Function
REQ-020 States: IDLE and BUSY only.
REQ-021 IDLE with any req_valid set: select the first set bit searching upward circularly from pointer rr; capture its write/addr/wdata into the bus_* registers, load grant_id, set bus_valid=1, clear the timeout counter, and enter BUSY on the same edge (request-to-bus_valid latency 1 cycle).
REQ-022 IDLE with no req_valid set: bus_valid=0, state, rr, and the bus_* registers hold.
REQ-023 BUSY: bus_write/bus_addr/bus_wdata SHALL stay constant; changes on req_* inputs are ignored.
REQ-024 BUSY with bus_valid && bus_ready: combinationally req_ready[grant_id]=1, req_rdata=bus_rdata, req_err=0; on the edge clear bus_valid, set rr=(grant_id+1) mod NUM_REQ, enter IDLE.
REQ-025 BUSY without bus_ready: the timeout counter increments by 1 per cycle, saturating.
REQ-026 Counter == TIMEOUT-1 and bus_ready=0: req_ready[grant_id]=1, req_err=1, req_rdata=0; on the edge clear bus_valid, advance rr as in REQ-024, enter IDLE.
REQ-027 If bus_ready arrives in the timeout cycle, normal completion wins: req_err=0 and req_rdata=bus_rdata.
REQ-028 Outside the completion cycle: req_ready=0, req_err=0, req_rdata=0.
REQ-029 Minimum inter-transfer gap: one IDLE cycle with bus_valid=0, so the slave's ready deasserts between transfers.
REQ-030 Requester dropping req_valid while granted: the transfer SHALL still complete on the bus and the req_ready pulse is issued regardless.
REQ-031 Fairness: a continuously requesting requester is granted within NUM_REQ-1 other transfers.

Reset
REQ-032 reset=1 at a clock edge forces IDLE, bus_valid=0, bus_write=0, bus_addr=0, bus_wdata=0, grant_id=0, rr=0, timeout counter=0.
REQ-033 Reset asserted during BUSY aborts the transfer with no req_ready pulse; the first arbitration after reset starts at requester 0.

Verification
REQ-034 Single read: req_valid[1]=1, addr 0x00204; DM slave returns 0xCAFEF00D -> bus_valid on cycle 1 with addr 0x00204; req_ready[1] pulse with req_rdata=0xCAFEF00D; req_err=0.
REQ-035 Contention: req_valid=2'b11 held, rr=0 -> grant order 0,1,0,1; one IDLE cycle between transfers; grant_id matches each bus transfer.
REQ-036 Timeout: TIMEOUT=8, bus_ready held 0 -> req_ready pulse with req_err=1 and req_rdata=0 in the 8th BUSY cycle; bus_valid=0 on the next cycle.
REQ-037 Ready in timeout cycle: bus_ready=1 exactly in BUSY cycle TIMEOUT with rdata 0x5 -> req_err=0, req_rdata=0x5.
REQ-038 Reset in BUSY: reset pulsed while a write is pending -> no req_ready pulse; bus_valid=0 next cycle; a subsequent request from both requesters grants requester 0 first.
REQ-039 Input stability: change req_addr[0] mid-BUSY -> bus_addr unchanged until completion.

Source files
------------

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter that funnels several requesters onto one DM bus slave port,
// aborting a transfer whose slave never answers within TIMEOUT busy cycles.
//
// state | meaning
// IDLE  | no transfer outstanding; arbitrate among req_valid each cycle
// BUSY  | bus_* registers hold the granted transfer until bus_ready or timeout
module dm_bus_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 255,
   parameter int ID_W    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*20-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [31:0]           req_rdata,
   output logic                  req_err,
   output logic [ID_W-1:0]       grant_id,
   output logic                  bus_valid,
   input  logic                  bus_ready,
   output logic                  bus_write,
   output logic [19:0]           bus_addr,
   output logic [31:0]           bus_wdata,
   input  logic [31:0]           bus_rdata
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam int              CNT_W   = 10;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

   logic [0:0]           state;
   logic [ID_W-1:0]      rr;
   logic [CNT_W-1:0]     to_cnt;

   logic [2*NUM_REQ-1:0] dbl_valid;
   logic [NUM_REQ-1:0]   rot_valid;
   logic                 sel_found;
   int                   sel_off;
   int                   sel_sum;
   logic [ID_W-1:0]      sel_idx;
   logic                 sel_write;
   logic [19:0]          sel_addr;
   logic [31:0]          sel_wdata;

   logic                 done_ok;
   logic                 done_to;
   logic                 done;

   // Rotating the request vector by rr turns the circular search into a
   // plain lowest-set-bit search.
   assign dbl_valid = {req_valid, req_valid} >> rr;
   assign rot_valid = dbl_valid[NUM_REQ-1:0];

   always_comb begin
      sel_found = 1'b0;
      sel_off   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            sel_found = 1'b1;
            sel_off   = k;
         end
      end
      sel_sum = int'(rr) + sel_off;
      if (sel_sum >= NUM_REQ) sel_sum = sel_sum - NUM_REQ;
      sel_idx = ID_W'(sel_sum);
   end

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_idx == ID_W'(i)) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[20*i +: 20];
            sel_wdata = req_wdata[32*i +: 32];
         end
      end
   end

   // A slave answer in the final timeout cycle still counts as a normal completion.
   assign done_ok = (state == BUSY) && bus_valid && bus_ready;
   assign done_to = (state == BUSY) && bus_valid && !bus_ready && (to_cnt == TO_LAST);
   assign done    = done_ok || done_to;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = done && (grant_id == ID_W'(i));
      end
   end

   assign req_rdata = done_ok ? bus_rdata : 32'h0;
   assign req_err   = done_to;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bus_valid <= 1'b0;
         bus_write <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         grant_id  <= '0;
         rr        <= '0;
         to_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  bus_write <= sel_write;
                  bus_addr  <= sel_addr;
                  bus_wdata <= sel_wdata;
                  grant_id  <= sel_idx;
                  bus_valid <= 1'b1;
                  to_cnt    <= '0;
                  state     <= BUSY;
               end else begin
                  bus_valid <= 1'b0;
               end
            end
            BUSY: begin
               if (done) begin
                  bus_valid <= 1'b0;
                  rr        <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
                  state     <= IDLE;
               end else if (to_cnt != '1) begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
